// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk ptr, ptr+1, ... (wrapping) and latch onto the first active request
    always_comb begin
        logic [IDX_W-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux with a bounded grant hold time.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic            s1,
    output logic            s0,
    output logic            busy,
    output logic            timeout
);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [NREQ-1:0]  gnt_n;
    logic [IDX_W-1:0] sel_n;
    logic             busy_n;
    logic             timeout_n;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] owner;
    logic             hold_hit;

    // The select lines double as the owner index register
    assign owner    = {s1, s0};
    assign hold_hit = (cnt == CNT_W'(MAX_HOLD - 1));

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic for the IDLE/GRANT machine
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        gnt_n     = gnt;
        sel_n     = owner;
        busy_n    = busy;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    sel_n           = pick_idx;
                    busy_n          = 1'b1;
                    cnt_n           = '0;
                    state_n         = GRANT;
                end
            end
            GRANT: begin
                if (done || !req[owner] || hold_hit) begin
                    gnt_n     = '0;
                    busy_n    = 1'b0;
                    ptr_n     = owner + IDX_W'(1);
                    state_n   = IDLE;
                    // Only a release forced purely by the hold limit counts as a timeout
                    timeout_n = hold_hit && !done && req[owner];
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            s1      <= 1'b0;
            s0      <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            s1      <= sel_n[1];
            s0      <= sel_n[0];
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed scenarios plus randomized traffic.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       s1, s0, busy, timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb[$];

    // Reference model: grant-level view of the arbiter
    int m_owner = -1;   // -1 when no grant is active
    int m_held  = 0;    // busy cycles elapsed in the current grant
    int m_ptr   = 0;
    int m_last  = 0;
    bit m_to    = 0;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .s1      (s1),
        .s0      (s0),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic [3:0] q, input logic d);
        bit found;
        m_to = 0;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!found && q[i]) begin
                    found   = 1;
                    m_owner = i;
                    m_last  = i;
                    m_held  = 1;
                end
            end
        end else begin
            if (d || !q[m_owner] || m_held == MAX_HOLD) begin
                m_to    = (m_held == MAX_HOLD) && !d && q[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic d);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = q;
        done = d;
        model_step(r, q, d);
        e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.sel  = 2'(m_last);
        e.busy = (m_owner >= 0);
        e.to   = m_to;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: after every rising edge, compare DUT outputs with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("gnt",     gnt,                 e.gnt);
                cmp("sel",     {2'b00, s1, s0},     {2'b00, e.sel});
                cmp("busy",    {3'b000, busy},      {3'b000, e.busy});
                cmp("timeout", {3'b000, timeout},   {3'b000, e.to});
            end
        end
    end

    initial begin
        logic [3:0] rq;
        // Reset
        drive(1, 4'b0000, 0);
        drive(1, 4'b0000, 0);
        drive(0, 4'b0000, 0);

        // Single requester 2, released by done
        repeat (3) drive(0, 4'b0100, 0);
        drive(0, 4'b0100, 1);
        repeat (2) drive(0, 4'b0000, 0);

        // All requesting, each grant released by done after two cycles
        repeat (5) begin
            drive(0, 4'b1111, 0);
            drive(0, 4'b1111, 0);
            drive(0, 4'b1111, 1);
        end
        repeat (2) drive(0, 4'b0000, 0);

        // Continuous request 0 with no done: hold-limit timeouts and re-grants
        repeat (40) drive(0, 4'b0001, 0);
        repeat (2) drive(0, 4'b0000, 0);

        // Owner 1 drops its request while 2 waits
        drive(1, 4'b0000, 0);
        repeat (3) drive(0, 4'b0110, 0);
        repeat (3) drive(0, 4'b0100, 0);
        repeat (2) drive(0, 4'b0000, 0);

        // done coincides with the hold limit
        drive(0, 4'b0001, 0);
        repeat (MAX_HOLD - 1) drive(0, 4'b0001, 0);
        drive(0, 4'b0001, 1);
        repeat (2) drive(0, 4'b0000, 0);

        // Reset in the middle of a grant to requester 3
        drive(0, 4'b1000, 0);
        drive(0, 4'b1000, 0);
        drive(1, 4'b1000, 0);
        repeat (3) drive(0, 4'b1001, 0);
        repeat (2) drive(0, 4'b0000, 0);

        // Randomized traffic with sticky requests, occasional done and reset
        rq = 4'($urandom);
        repeat (2000) begin
            if ($urandom_range(0, 99) < 20) rq = 4'($urandom);
            drive(($urandom_range(0, 199) == 0), rq, ($urandom_range(0, 9) == 0));
        end
        repeat (2) drive(0, 4'b0000, 0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 data mux between four requesters. It grants one requester at a time and drives the mux select pair from the granted index. It also enforces a maximum hold time. It sits beside the mux: requesters raise `req`, and the arbiter returns a one-hot `gnt` and steers `s1,s0` so the winner's data reaches `data_out`.

## Interface
- `MAX_HOLD`, default 15: maximum number of cycles one grant may be held before forced release. Legal range is 1..255.
- `CNT_W`, default 8: width of the hold counter. Must satisfy `MAX_HOLD <= 2**CNT_W - 1`.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  4: request lines; `req[i]` is requester i (mux input d_i).
- `done`  in  1: release strobe from the current owner; only meaningful while `busy`.
- `gnt`  out  4: one-hot grant, registered; all zero when idle.
- `s1`  out  1: mux select MSB, equal to owner index bit 1.
- `s0`  out  1: mux select LSB, equal to owner index bit 0.
- `busy`  out  1: high while a grant is active.
- `timeout`  out  1: single-cycle pulse when a grant is force-released by the hold limit.

## Operation
- State machine with two states, IDLE and GRANT.
- Reset values:
  - State is IDLE.
  - `gnt`=0000, `s1,s0`=00, `busy`=0, `timeout`=0.
  - Priority pointer `ptr`=0; hold counter `cnt`=0.
- IDLE:
  - If `req` is nonzero, choose the winner: the first set bit searching i = ptr, ptr+1, ... mod 4.
  - On the next edge: `gnt` becomes one-hot of the winner, `s1,s0` become the winner index, `busy`=1, `cnt`=0, state moves to GRANT.
  - If `req`=0000, stay in IDLE and leave all outputs unchanged.
- GRANT (owner o):
  - The grant ends when any of these holds at a clock edge:
    - `done`=1, or
    - `req[o]`=0, or
    - `cnt` == MAX_HOLD-1.
  - On that edge: `gnt`=0000, `busy`=0, `ptr` = (o+1) mod 4, state moves to IDLE.
  - `timeout`=1 for exactly that one cycle, only if the hold limit was the sole cause. If `done` or request drop coincides with the limit, no timeout.
  - Otherwise `cnt` increments by 1.
- `s1,s0` keep the last owner index in IDLE. They are valid only when `busy`=1.
- Requests from non-owners are ignored during GRANT. There is no preemption.
- `ptr` only advances on release, which guarantees fairness: every continuously requesting input is granted within 3 intervening grants.
- `rst` asserted in any state, including mid-grant, forces the reset values on that edge. An owner receives no `done` handshake for the aborted grant.

## Timing
- Grant latency: `req` sampled high at edge N with the arbiter in IDLE gives `gnt`, `busy`, `s1,s0` valid after edge N, that is, during cycle N+1.
- One mandatory IDLE cycle separates consecutive grants. Back-to-back owners are therefore spaced by a minimum of 1 idle cycle.
- A grant lasts at most MAX_HOLD cycles of `busy`=1.
- `timeout` rises in the same cycle that `busy` falls.
- All outputs are registered; there is no combinational path from `req` or `done` to any output.
- Mux data path: `data_out` reflects the owner's `d` input combinationally once `s1,s0` update. No extra latency is added by the arbiter.

## Structure
- Shared package `mux_arb_pkg` contains:
  - The state enum {IDLE, GRANT}.
  - The constant `NREQ`=4.
  - The constant `IDX_W`=2.
- Sub-module `rr_pick`: a purely combinational rotating priority encoder.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `valid`, `idx[1:0]`.
  - It is instantiated once by `mux_rr_arbiter`.
- The top level may instantiate the existing `mux` with `s1,s0` for integration testing. `mux_rr_arbiter` itself does not contain the mux.

## Test plan
- Reset then `req`=0100: `gnt`=0100 and `s1,s0`=10 one cycle later. Pulse `done` → `gnt`=0000 next edge, `ptr`=3.
- `req`=1111 held, releasing each grant with `done` after 2 cycles: grant order 0,1,2,3,0 with one idle cycle between grants.
- `req`=0001 held, no `done`, MAX_HOLD=15: `busy` high for exactly 15 cycles, `timeout` pulses once as `busy` falls, then re-grant to 0 after one IDLE cycle.
- Owner 1 drops `req[1]` mid-grant while `req[2]` is high: release on that edge, then `gnt`=0100 after the idle cycle.
- `done` and the hold limit coincide on the same edge: release occurs and `timeout` stays 0.
- `rst` pulsed while `gnt`=1000: next edge `gnt`=0000, `s1,s0`=00, `busy`=0, and `req`=1001 then grants 0, since `ptr` was reset.
